biquad_seq_ctrl: RTL

- Sequencer for the shared single-MAC datapath of the second-order IIR section.
- Drives the coefficient, state and input mux selects (controlS, controlC, controlZ) plus accumulator and register strobes.
- Computes, per sample, in direct form II:
  - f(k) = u(k) + a1·f(k-1) + a2·f(k-2)
  - y(k) = b0·f(k) + b1·f(k-1) + b2·f(k-2)
- Sits between the sample-rate tick source and the mux/MAC/register datapath.

---
 rtl/biquad_pkg.sv | 111 +++++++++++
 rtl/biquad_tick_gen.sv | 49 ++++
 rtl/biquad_seq_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/biquad_pkg.sv
// -----------------------------------------------------------------------------
// biquad_pkg
// Shared definitions for the biquad sequencer and its datapath:
//   - FSM state encoding (IDLE=0 .. STORE_Y=8)
//   - mux select codes; these must match the datapath mux encoding
//   - control-word struct and its per-state decode
//   - default sample period (clocks per sample) for the automatic tick source
// -----------------------------------------------------------------------------
package biquad_pkg;

  localparam int TICK_DIV_DEFAULT = 2000;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_U  = 4'd1,
    MAC_A1  = 4'd2,
    MAC_A2  = 4'd3,
    STORE_F = 4'd4,
    MAC_B0  = 4'd5,
    MAC_B1  = 4'd6,
    MAC_B2  = 4'd7,
    STORE_Y = 4'd8
  } state_e;

  // Coefficient select (controlS)
  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_A1   = 3'd1;
  localparam logic [2:0] SEL_A2   = 3'd2;
  localparam logic [2:0] SEL_B0   = 3'd3;
  localparam logic [2:0] SEL_B1   = 3'd4;
  localparam logic [2:0] SEL_B2   = 3'd5;
  // State select (controlC)
  localparam logic [1:0] SEL_FK1  = 2'd1;
  localparam logic [1:0] SEL_FK2  = 2'd2;
  localparam logic [1:0] SEL_FK   = 2'd3;
  // Input select (controlZ)
  localparam logic [1:0] SEL_UK   = 2'd1;
  localparam logic [1:0] SEL_YK   = 2'd2;

  typedef struct packed {
    logic [2:0] sel_s;
    logic [1:0] sel_c;
    logic [1:0] sel_z;
    logic       acc_ld;
    logic       acc_en;
    logic       fk_en;
    logic       yk_en;
    logic       shift_en;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Moore output decode: one control word per state, zero in IDLE.
  function automatic ctrl_t decode_state(input state_e st);
    ctrl_t c;
    c       = '0;
    c.sel_s = SEL_ZERO;
    c.sel_c = SEL_ZERO[1:0];
    c.sel_z = SEL_ZERO[1:0];
    c.busy  = (st != IDLE);
    case (st)
      IDLE: begin
        c.busy = 1'b0;
      end
      LOAD_U: begin
        c.sel_z  = SEL_UK;
        c.acc_ld = 1'b1;
      end
      MAC_A1: begin
        c.sel_s  = SEL_A1;
        c.sel_c  = SEL_FK1;
        c.acc_en = 1'b1;
      end
      MAC_A2: begin
        c.sel_s  = SEL_A2;
        c.sel_c  = SEL_FK2;
        c.acc_en = 1'b1;
      end
      STORE_F: begin
        // Latch f(k) and reload acc with zero in the same cycle.
        c.fk_en  = 1'b1;
        c.acc_ld = 1'b1;
      end
      MAC_B0: begin
        c.sel_s  = SEL_B0;
        c.sel_c  = SEL_FK;
        c.acc_en = 1'b1;
      end
      MAC_B1: begin
        c.sel_s  = SEL_B1;
        c.sel_c  = SEL_FK1;
        c.acc_en = 1'b1;
      end
      MAC_B2: begin
        c.sel_s  = SEL_B2;
        c.sel_c  = SEL_FK2;
        c.acc_en = 1'b1;
      end
      STORE_Y: begin
        c.yk_en    = 1'b1;
        c.shift_en = 1'b1;
        c.done     = 1'b1;
      end
      default: begin
        c      = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/biquad_tick_gen.sv
// -----------------------------------------------------------------------------
// biquad_tick_gen
// Free-running sample-period counter 0..TICK_DIV-1; tick_o is high for the one
// cycle in which the count equals TICK_DIV-1. Counter held at 0 in reset.
// Only instantiated when BIQUAD_AUTO_TICK_EN is defined.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   tick_o   one-cycle sample request (registered)
// -----------------------------------------------------------------------------
module biquad_tick_gen #(
  parameter int TICK_DIV = 2000,
  parameter int TICK_W   = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] count_d;
  logic              tick_q;

  // Next count with wrap at TICK_DIV-1.
  always_comb begin
    count_d = count_q;
    if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + TICK_W'(1);
    end
  end

  // Counter and registered tick; tick_q is high exactly while count_q == LAST.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= (count_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/biquad_seq_ctrl.sv
// -----------------------------------------------------------------------------
// biquad_seq_ctrl
// Moore sequencer for the single-MAC direct-form-II biquad datapath:
//   f(k) = u(k) + a1*f(k-1) + a2*f(k-2)
//   y(k) = b0*f(k) + b1*f(k-1) + b2*f(k-2)
// One sample takes 8 busy cycles (LOAD_U..STORE_Y) then returns to IDLE.
// All outputs are registered and depend on the state only.
// Optional build macro BIQUAD_AUTO_TICK_EN: an internal counter of TICK_DIV
// clocks replaces the start port as the sample request.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle sample request (ignored with auto tick)
//   clr_overrun          clears sticky overrun (a simultaneous set wins)
//   controlS/C/Z         coefficient / state / input mux selects
//   acc_ld, acc_en       accumulator load / multiply-accumulate
//   fk_en, yk_en         f(k) and y(k) register loads
//   shift_en             delay-line shift fk2<=fk1, fk1<=fk
//   busy, done, overrun  status
// -----------------------------------------------------------------------------
module biquad_seq_ctrl
  import biquad_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clr_overrun,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [1:0] controlZ,
  output logic       acc_ld,
  output logic       acc_en,
  output logic       fk_en,
  output logic       yk_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;
  logic   overrun_q;
  logic   req_s;

`ifdef BIQUAD_AUTO_TICK_EN
  logic tick_s;
  logic unused_start_s;

  biquad_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk_i   (clk),
    .reset_i (reset),
    .tick_o  (tick_s)
  );

  assign req_s          = tick_s;
  assign unused_start_s = start;
`else
  assign req_s = start;
`endif

  // Next-state: only IDLE waits for a request, every other state advances.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = LOAD_U;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_U:  state_d = MAC_A1;
      MAC_A1:  state_d = MAC_A2;
      MAC_A2:  state_d = STORE_F;
      STORE_F: state_d = MAC_B0;
      MAC_B0:  state_d = MAC_B1;
      MAC_B1:  state_d = MAC_B2;
      MAC_B2:  state_d = STORE_Y;
      STORE_Y: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered control word (decoded from the next state so it lines
  // up with state_q) and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
      if (req_s && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end
    end
  end

  assign controlS = ctrl_q.sel_s;
  assign controlC = ctrl_q.sel_c;
  assign controlZ = ctrl_q.sel_z;
  assign acc_ld   = ctrl_q.acc_ld;
  assign acc_en   = ctrl_q.acc_en;
  assign fk_en    = ctrl_q.fk_en;
  assign yk_en    = ctrl_q.yk_en;
  assign shift_en = ctrl_q.shift_en;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign overrun  = overrun_q;

endmodule
